// File: rtl/path_deque.sv
`default_nettype none
// ============================================================================
// Module      : path_deque
// Description : Double-ended move store. Moves are pushed at the tail and can
//               be removed newest-first (pop, backtracking) or oldest-first
//               (qpop, path replay). Circular buffer with head/tail pointers.
// Revision    : 1.0  initial release
// ============================================================================
module path_deque #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       qpop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic [WIDTH-1:0]           top,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] C_ONE_PTR = 1;
  localparam logic [CW-1:0] C_ONE_CNT = 1;
  localparam logic [CW-1:0] C_DEPTH   = DEPTH[CW-1:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_err;

  logic [AW-1:0]    w_tail_m1;
  logic             w_empty;
  logic             w_full;
  logic             w_write;
  logic             w_rd_head;
  logic             w_rd_tail;
  logic             w_err;

  assign w_tail_m1 = r_tail - C_ONE_PTR;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_DEPTH);

  // Decode the request combination into write / read-head / read-tail / error
  always_comb begin
    w_write   = 1'b0;
    w_rd_head = 1'b0;
    w_rd_tail = 1'b0;
    w_err     = 1'b0;
    case ({push, pop, qpop})
      3'b000: ;
      3'b100: if (w_full)  w_err = 1'b1; else w_write   = 1'b1;
      3'b010: if (w_empty) w_err = 1'b1; else w_rd_tail = 1'b1;
      3'b001: if (w_empty) w_err = 1'b1; else w_rd_head = 1'b1;
      // Streaming replay: remove oldest and append newest, legal even when full
      3'b101: begin
        if (w_empty) begin
          w_err = 1'b1;
        end else begin
          w_write   = 1'b1;
          w_rd_head = 1'b1;
        end
      end
      default: w_err = 1'b1;
    endcase
  end

  // Pointer, occupancy and output-register update; reset beats clear beats ops
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_err        <= 1'b0;
    end else if (clear) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_dout_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_dout_valid <= w_rd_head | w_rd_tail;
      r_err        <= w_err;
      if (w_rd_head) begin
        r_dout <= r_mem[r_head];
        r_head <= r_head + C_ONE_PTR;
      end
      if (w_rd_tail) begin
        r_dout <= r_mem[w_tail_m1];
        r_tail <= w_tail_m1;
      end
      if (w_write) begin
        r_tail <= r_tail + C_ONE_PTR;
      end
      if (w_write && !w_rd_head) begin
        r_count <= r_count + C_ONE_CNT;
      end else if (!w_write && (w_rd_head || w_rd_tail)) begin
        r_count <= r_count - C_ONE_CNT;
      end
    end
  end

  // Storage array; contents deliberately survive reset and clear
  always_ff @(posedge clk) begin
    if (rst && !clear && w_write) begin
      r_mem[r_tail] <= din;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign err        = r_err;
  assign count      = r_count;
  assign empty      = w_empty;
  assign full       = w_full;
  assign top        = w_empty ? '0 : r_mem[w_tail_m1];

endmodule
`default_nettype wire

// File: tb/tb_path_deque.sv
`default_nettype none
// ============================================================================
// Module      : tb_path_deque
// Description : Self-checking bench for path_deque (WIDTH=4, DEPTH=4): vector
//               table, a wrap-around sequence and randomized traffic against a
//               queue-based reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_path_deque;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             clear;
  logic             push;
  logic             pop;
  logic             qpop;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [WIDTH-1:0] top;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic             rst;
    logic             clr;
    logic             push;
    logic             pop;
    logic             qpop;
    logic [WIDTH-1:0] din;
    int               cnt;
    logic [WIDTH-1:0] dout;
    logic             dv;
    logic             err;
    logic [WIDTH-1:0] top;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_dv;
  logic             m_err;

  path_deque #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .push       (push),
    .pop        (pop),
    .qpop       (qpop),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .top        (top),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic c, input logic pu, input logic po,
                     input logic qp, input int d, input int cnt, input int dq,
                     input logic dv, input logic e, input int tp);
    vec_t v;
    v.rst = r; v.clr = c; v.push = pu; v.pop = po; v.qpop = qp;
    v.din = WIDTH'(d); v.cnt = cnt; v.dout = WIDTH'(dq); v.dv = dv;
    v.err = e; v.top = WIDTH'(tp);
    vecs.push_back(v);
  endtask

  // Behavioural model: deque semantics directly on a SystemVerilog queue
  task automatic model_step(input logic r, input logic c, input logic pu,
                            input logic po, input logic qp, input logic [WIDTH-1:0] d);
    if (!r) begin
      mq.delete(); m_dout = '0; m_dv = 1'b0; m_err = 1'b0;
    end else if (c) begin
      mq.delete(); m_dv = 1'b0; m_err = 1'b0;
    end else begin
      m_dv = 1'b0; m_err = 1'b0;
      case ({pu, po, qp})
        3'b000: ;
        3'b100: if (mq.size() == DEPTH) m_err = 1'b1; else mq.push_back(d);
        3'b010: if (mq.size() == 0) m_err = 1'b1;
                else begin m_dout = mq.pop_back(); m_dv = 1'b1; end
        3'b001: if (mq.size() == 0) m_err = 1'b1;
                else begin m_dout = mq.pop_front(); m_dv = 1'b1; end
        3'b101: if (mq.size() == 0) m_err = 1'b1;
                else begin m_dout = mq.pop_front(); mq.push_back(d); m_dv = 1'b1; end
        default: m_err = 1'b1;
      endcase
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later
  task automatic apply(input logic r, input logic c, input logic pu, input logic po,
                       input logic qp, input logic [WIDTH-1:0] d);
    @(negedge clk);
    rst = r; clear = c; push = pu; pop = po; qpop = qp; din = d;
    @(posedge clk);
    #1;
    model_step(r, c, pu, po, qp, d);
  endtask

  task automatic check_model();
    check("rnd_count", int'(count), mq.size());
    check("rnd_empty", int'(empty), int'(mq.size() == 0));
    check("rnd_full",  int'(full),  int'(mq.size() == DEPTH));
    check("rnd_top",   int'(top),   (mq.size() == 0) ? 0 : int'(mq[$]));
    check("rnd_dout",  int'(dout),  int'(m_dout));
    check("rnd_dv",    int'(dout_valid), int'(m_dv));
    check("rnd_err",   int'(err),   int'(m_err));
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; qpop = 1'b0; din = '0;

    //   rst clr pu po qp din | cnt dout dv err top
    // reset held with push asserted
    add(0, 0, 1, 0, 0, 5,    0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 5,    0, 0, 0, 0, 0);
    // LIFO
    add(1, 0, 1, 0, 0, 1,    1, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 2,    2, 0, 0, 0, 2);
    add(1, 0, 1, 0, 0, 3,    3, 0, 0, 0, 3);
    add(1, 0, 0, 1, 0, 0,    2, 3, 1, 0, 2);
    add(1, 0, 0, 1, 0, 0,    1, 2, 1, 0, 1);
    add(1, 0, 0, 1, 0, 0,    0, 1, 1, 0, 0);
    // pop when empty, then idle clears the pulse
    add(1, 0, 0, 1, 0, 0,    0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0,    0, 1, 0, 0, 0);
    // fill to full
    add(1, 0, 1, 0, 0, 0,    1, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 1,    2, 1, 0, 0, 1);
    add(1, 0, 1, 0, 0, 2,    3, 1, 0, 0, 2);
    add(1, 0, 1, 0, 0, 3,    4, 1, 0, 0, 3);
    // streaming replay while full, both pointers wrap
    add(1, 0, 1, 0, 1, 8,    4, 0, 1, 0, 8);
    add(1, 0, 1, 0, 1, 9,    4, 1, 1, 0, 9);
    add(1, 0, 1, 0, 1, 10,   4, 2, 1, 0, 10);
    add(1, 0, 1, 0, 1, 11,   4, 3, 1, 0, 11);
    // push when full
    add(1, 0, 1, 0, 0, 7,    4, 3, 0, 1, 11);
    // down to two entries, then illegal combinations
    add(1, 0, 0, 0, 1, 0,    3, 8, 1, 0, 11);
    add(1, 0, 0, 0, 1, 0,    2, 9, 1, 0, 11);
    add(1, 0, 1, 1, 0, 5,    2, 9, 0, 1, 11);
    add(1, 0, 0, 1, 1, 0,    2, 9, 0, 1, 11);
    add(1, 0, 1, 1, 1, 5,    2, 9, 0, 1, 11);
    // clear mid-run with push asserted; dout survives clear
    add(1, 0, 1, 0, 0, 6,    3, 9, 0, 0, 6);
    add(1, 1, 1, 0, 0, 7,    0, 9, 0, 0, 0);
    add(1, 0, 1, 0, 0, 2,    1, 9, 0, 0, 2);
    add(1, 0, 0, 0, 1, 0,    0, 2, 1, 0, 0);
    // push+qpop on empty is an error
    add(1, 0, 1, 0, 1, 4,    0, 2, 0, 1, 0);
    // reset mid-run zeroes dout
    add(0, 0, 1, 0, 0, 4,    0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].clr, vecs[i].push, vecs[i].pop, vecs[i].qpop, vecs[i].din);
      check($sformatf("v%0d_count", i), int'(count), vecs[i].cnt);
      check($sformatf("v%0d_empty", i), int'(empty), int'(vecs[i].cnt == 0));
      check($sformatf("v%0d_full", i),  int'(full),  int'(vecs[i].cnt == DEPTH));
      check($sformatf("v%0d_dout", i),  int'(dout),  int'(vecs[i].dout));
      check($sformatf("v%0d_dv", i),    int'(dout_valid), int'(vecs[i].dv));
      check($sformatf("v%0d_err", i),   int'(err),   int'(vecs[i].err));
      check($sformatf("v%0d_top", i),   int'(top),   int'(vecs[i].top));
    end

    // Pop across the tail wrap, dout holds over idle cycles, then qpop oldest
    apply(1, 0, 0, 0, 0, 0);
    apply(1, 0, 1, 0, 0, 4'd12);
    apply(1, 0, 1, 0, 0, 4'd13);
    apply(1, 0, 1, 0, 0, 4'd14);
    apply(1, 0, 1, 0, 0, 4'd15);
    check("wrap_full", int'(full), 1);
    apply(1, 0, 0, 1, 0, 0);
    check("wrap_pop_dout", int'(dout), 15);
    check("wrap_pop_dv", int'(dout_valid), 1);
    check("wrap_pop_top", int'(top), 14);
    for (int k = 0; k < 3; k++) begin
      apply(1, 0, 0, 0, 0, 0);
      check("hold_dout", int'(dout), 15);
      check("hold_dv", int'(dout_valid), 0);
    end
    apply(1, 0, 0, 0, 1, 0);
    check("wrap_qpop_dout", int'(dout), 12);
    check("wrap_qpop_count", int'(count), 2);
    check("wrap_qpop_top", int'(top), 14);

    // Randomized traffic against the queue model
    apply(0, 0, 0, 0, 0, 0);
    check_model();
    for (int n = 0; n < 800; n++) begin
      logic r, c, pu, po, qp;
      int sel;
      r = ($urandom_range(63) != 0);
      c = ($urandom_range(31) == 0);
      sel = $urandom_range(9);
      {pu, po, qp} = 3'b000;
      if (sel <= 3)      {pu, po, qp} = 3'b100;
      else if (sel <= 5) {pu, po, qp} = 3'b010;
      else if (sel <= 7) {pu, po, qp} = 3'b001;
      else if (sel == 8) {pu, po, qp} = 3'b101;
      else               {pu, po, qp} = 3'($urandom_range(7));
      apply(r, c, pu, po, qp, WIDTH'($urandom_range(15)));
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
